// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and status readback.

package mmio_uart_tx_pkg;
    localparam int unsigned XLEN = 32;

    // Write request from the hart's memory stage
    typedef struct packed {
        logic            enable;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] value;
        logic [1:0]      width;
    } mem_write_control_t;
endpackage

module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [XLEN-1:0] base_addr        = 32'h0000_8000,
    parameter int unsigned     fifo_depth       = 8,
    parameter logic [15:0]     default_baud_div = 16'd16
) (
    input  logic               clock,
    input  logic               reset,
    input  mem_write_control_t memory_mapped_io_control,
    output logic               memory_mapped_io_write_complete,
    output logic [XLEN-1:0]    memory_mapped_io_r_data,
    output logic               uart_tx
);

    localparam int unsigned AW = $clog2(fifo_depth);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [fifo_depth];
    logic [7:0]      mem_d [fifo_depth];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     baud_div_q, baud_div_d;
    logic [15:0]     bit_div_q, bit_div_d;
    logic [15:0]     timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            is_txdata;
    logic            is_baud;
    logic            write_complete;
    logic            push;
    logic            baud_wr;
    logic            pop;
    logic            bit_end;
    logic [7:0]      head;

    assign fifo_full  = (count_q == CW'(fifo_depth));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // Address decode and write handshake; TXDATA stalls only while the FIFO is full
    always_comb begin
        is_txdata      = (memory_mapped_io_control.addr == base_addr);
        is_baud        = (memory_mapped_io_control.addr == base_addr + XLEN'(4));
        write_complete = 1'b0;
        if (reset && memory_mapped_io_control.enable) begin
            write_complete = is_txdata ? !fifo_full : 1'b1;
        end
        push    = write_complete && is_txdata;
        baud_wr = write_complete && is_baud;
    end

    // FIFO storage, pointers, occupancy and the baud divisor register
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        baud_div_d = baud_div_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = memory_mapped_io_control.value[7:0];
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (baud_wr) begin
            baud_div_d = (memory_mapped_io_control.value[15:0] == 16'd0)
                       ? 16'd1 : memory_mapped_io_control.value[15:0];
        end
    end

    // TX FSM next state; a pop latches the byte and the divisor for the whole frame
    always_comb begin
        state_d   = state_q;
        bit_div_d = bit_div_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        bit_end   = (timer_q == 16'd0);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    timer_d   = bit_div_q - 16'd1;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    timer_d = bit_div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            shift_d   = head;
            bit_div_d = baud_div_q;
            timer_d   = baud_div_q - 16'd1;
            tx_d      = 1'b0;
            state_d   = S_START;
        end
    end

    // State registers; reset aborts any frame and returns the line high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_div_q <= default_baud_div;
            bit_div_q  <= default_baud_div;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            baud_div_q <= baud_div_d;
            bit_div_q  <= bit_div_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign memory_mapped_io_write_complete = write_complete;
    assign uart_tx                         = tx_q;
    assign memory_mapped_io_r_data = {baud_div_q, 8'(count_q), 5'd0,
                                      (state_q != S_IDLE), fifo_empty, fifo_full};

    // Access width and upper data bits carry no meaning for this device
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^{memory_mapped_io_control.width,
                                memory_mapped_io_control.value[XLEN-1:16]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: bytes queued on accept, checked as frames leave the pin.

module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_8000;
    localparam logic [31:0] RST_R = 32'h0010_0002;

    logic               clock;
    logic               reset;
    mem_write_control_t ctrl;
    logic               wc;
    logic [31:0]        r_data;
    logic               uart_tx;

    mmio_uart_tx #(
        .base_addr       (BASE),
        .fifo_depth      (8),
        .default_baud_div(16'd16)
    ) dut (
        .clock                          (clock),
        .reset                          (reset),
        .memory_mapped_io_control       (ctrl),
        .memory_mapped_io_write_complete(wc),
        .memory_mapped_io_r_data        (r_data),
        .uart_tx                        (uart_tx)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         model_baud = 16;
    logic [7:0] exp_q[$];
    int         start_cyc_q[$];
    int         frames_done = 0;
    int         starts_seen = 0;
    int         last_start  = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one write from a negedge; hold it until accepted or max_wait cycles pass
    task automatic mmio_write(input logic [31:0] addr, input logic [31:0] val, input int max_wait,
                              output bit accepted, output int waited, output int acc_cyc);
        ctrl.enable = 1'b1;
        ctrl.addr   = addr;
        ctrl.value  = val;
        ctrl.width  = 2'd2;
        accepted = 1'b0;
        waited   = 0;
        acc_cyc  = -1;
        while (!accepted && waited <= max_wait) begin
            #1;
            if (wc === 1'b1) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
            @(posedge clock);
            if (accepted) begin
                if (addr == BASE) exp_q.push_back(val[7:0]);
                else if (addr == BASE + 32'd4) model_baud = (val[15:0] == 16'd0) ? 1 : int'(val[15:0]);
            end else begin
                waited++;
            end
            @(negedge clock);
        end
        ctrl.enable = 1'b0;
    endtask

    task automatic wr_ok(input string tag, input logic [31:0] addr, input logic [31:0] val);
        bit a;
        int w;
        int c;
        mmio_write(addr, val, 0, a, w, c);
        check(tag, 32'(a), 32'd1);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frames_done < n && t < budget) begin
            @(negedge clock);
            t++;
        end
        check("frames_seen", 32'(frames_done), 32'(n));
    endtask

    task automatic wait_start(input int prev, input int budget);
        int t = 0;
        while (starts_seen == prev && t < budget) begin
            @(negedge clock);
            t++;
        end
        check("start_seen", 32'(starts_seen), 32'(prev + 1));
    endtask

    // Line monitor: captures a whole frame, compares shape and byte against the scoreboard
    initial begin : monitor
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic       e;
        int         div;
        int         bad;
        int         bi;
        int         st;
        bit         aborted;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && uart_tx === 1'b0) begin
                div = model_baud;
                st  = cyc;
                starts_seen++;
                last_start = st;
                exp_b   = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
                got_b   = 8'h00;
                bad     = 0;
                aborted = 1'b0;
                for (int k = 0; k < 10 * div; k++) begin
                    if (k > 0) @(negedge clock);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k < div) begin
                        e = 1'b0;
                    end else if (k < 9 * div) begin
                        bi = (k - div) / div;
                        e  = exp_b[bi];
                        if ((k - div) % div == div / 2) got_b[bi] = uart_tx;
                    end else begin
                        e = 1'b1;
                    end
                    if (uart_tx !== e) bad++;
                end
                if (!aborted) begin
                    check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    check("frame_byte", 32'(got_b), 32'(exp_b));
                    check("frame_shape", 32'(bad), 32'd0);
                    start_cyc_q.push_back(st);
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin : main
        bit a;
        int w;
        int n;
        int n2;
        int b;
        int s;
        int fd;
        int ss;

        ctrl  = '0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset state, including a request held during reset
        ctrl.enable = 1'b1;
        ctrl.addr   = BASE;
        repeat (3) @(negedge clock);
        #1;
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_rdata", r_data, RST_R);
        check("rst_wc", 32'(wc), 32'd0);
        ctrl.enable = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single frame 0xA5 at divisor 4: latency and 40-cycle length
        wr_ok("wr_baud4", BASE + 32'd4, 32'd4);
        b = frames_done;
        mmio_write(BASE, 32'hA5, 0, a, w, n);
        check("a5_wc_same_cycle", 32'(a), 32'd1);
        wait_cyc(n + 41);
        check("a5_last_stop_busy", 32'(r_data[2]), 32'd1);
        check("a5_last_stop_tx", 32'(uart_tx), 32'd1);
        @(negedge clock);
        check("a5_idle_after_40", 32'(r_data[2]), 32'd0);
        wait_frames(b + 1, 20);
        check("a5_start_latency", 32'(start_cyc_q[b]), 32'(n + 2));

        // Divisor 0 clamps to 1
        wr_ok("wr_baud0", BASE + 32'd4, 32'd0);
        check("baud0_reads_1", 32'(r_data[31:16]), 32'd1);
        b = frames_done;
        wr_ok("wr_3c", BASE, 32'h3C);
        wait_frames(b + 1, 40);

        // Divisor change mid-frame applies from the next frame
        wr_ok("wr_baud6", BASE + 32'd4, 32'd6);
        b = frames_done;
        mmio_write(BASE, 32'h96, 0, a, w, n);
        wr_ok("wr_69", BASE, 32'h69);
        wait_cyc(n + 12);
        wr_ok("wr_baud3_mid", BASE + 32'd4, 32'd3);
        check("baud3_reads", 32'(r_data[31:16]), 32'd3);
        wait_frames(b + 2, 200);
        check("mid_frame_keeps_div", 32'(start_cyc_q[b + 1] - start_cyc_q[b]), 32'd60);

        // Backpressure: lead frame in flight, 8 bytes fill FIFO, 9th stalls until pop
        wr_ok("wr_baud2", BASE + 32'd4, 32'd2);
        b = frames_done;
        mmio_write(BASE, 32'h11, 0, a, w, n);
        wait_cyc(n + 2);
        for (int i = 0; i < 8; i++) begin
            wr_ok("fill_wc", BASE, 32'(8'h20 + 8'(i * 7)));
        end
        check("full_flag", 32'(r_data[0]), 32'd1);
        check("full_count", 32'(r_data[15:8]), 32'd8);
        #1;
        ctrl.enable = 1'b1;
        ctrl.addr   = BASE;
        #1;
        check("full_wc_low", 32'(wc), 32'd0);
        ctrl.enable = 1'b0;
        mmio_write(BASE, 32'hEE, 40, a, w, n2);
        check("ninth_accepted", 32'(a), 32'd1);
        check("ninth_accept_cycle", 32'(n2), 32'(n + 22));
        wait_frames(b + 10, 260);
        for (int i = 1; i < 10; i++) begin
            check("b2b_gap", 32'(start_cyc_q[b + i] - start_cyc_q[b + i - 1]), 32'd20);
        end

        // Unmapped address: acknowledged and dropped
        fd = frames_done;
        ss = starts_seen;
        mmio_write(BASE + 32'd8, 32'hFF, 0, a, w, n);
        check("unmapped_wc", 32'(a), 32'd1);
        check("unmapped_count", 32'(r_data[15:8]), 32'd0);
        repeat (6) @(negedge clock);
        check("unmapped_tx", 32'(uart_tx), 32'd1);
        check("unmapped_no_start", 32'(starts_seen), 32'(ss));

        // Push and pop in the same cycle on the last stop cycle
        b = frames_done;
        ss = starts_seen;
        wr_ok("wr_c3", BASE, 32'hC3);
        wr_ok("wr_3a", BASE, 32'h3A);
        wait_start(ss, 20);
        s = last_start;
        wait_cyc(s + 19);
        check("pp_count_before", 32'(r_data[15:8]), 32'd1);
        mmio_write(BASE, 32'h7E, 0, a, w, n);
        check("pp_accept_cycle", 32'(n), 32'(s + 19));
        check("pp_count_after", 32'(r_data[15:8]), 32'd1);
        wait_frames(b + 3, 120);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset during DATA with three bytes queued
        wr_ok("wr_baud4b", BASE + 32'd4, 32'd4);
        ss = starts_seen;
        for (int i = 0; i < 4; i++) wr_ok("rst_fill", BASE, 32'(8'hD1 + 8'(i)));
        wait_start(ss, 20);
        s = last_start;
        wait_cyc(s + 10);
        #2 reset = 1'b0;
        #1;
        check("midrst_tx", 32'(uart_tx), 32'd1);
        check("midrst_rdata", r_data, RST_R);
        exp_q.delete();
        model_baud = 16;
        @(negedge clock);
        #2 reset = 1'b1;
        fd = frames_done;
        ss = starts_seen;
        repeat (60) @(negedge clock);
        check("postrst_no_frame", 32'(starts_seen), 32'(ss));
        check("postrst_tx", 32'(uart_tx), 32'd1);
        check("postrst_rdata", r_data, RST_R);
        check("postrst_frames", 32'(frames_done), 32'(fd));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
